// File: rtl/mux_ctrl_rr_pkg.sv
// Shared definitions for the crossbar select controller: integration sizes,
// arbiter state encoding and the select-field width helper.
package mux_ctrl_rr_pkg;

    localparam int PORT_NUB_TOTAL = 4;
    localparam int DATA_WIDTH     = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Select-field width; never collapses to zero bits.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_cell.sv
// One output's arbiter: round-robin or fixed-priority winner pick, packet lock
// FSM, rotating pointer and last select. The winner is combinational; state is registered.
module mux_arb_cell
    import mux_ctrl_rr_pkg::*;
#(
    parameter int  PORT_NUB  = 4,
    parameter int  MODE      = 1,
    localparam int WIDTH_SEL = sel_width(PORT_NUB)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PORT_NUB-1:0]  req_i,
    input  logic [PORT_NUB-1:0]  last_i,
    input  logic                 full_i,
    output logic                 accept_o,
    output logic [WIDTH_SEL-1:0] sel_o,
    output logic [PORT_NUB-1:0]  grant_o,
    output logic                 busy_o
);

    localparam logic [WIDTH_SEL-1:0] LAST_IDX = WIDTH_SEL'(PORT_NUB - 1);

    arb_state_e           fsm_q, fsm_d;
    logic [WIDTH_SEL-1:0] ptr_q, ptr_d;
    logic [WIDTH_SEL-1:0] owner_q, owner_d;
    logic [WIDTH_SEL-1:0] last_sel_q, last_sel_d;

    logic                 found_s;
    logic [WIDTH_SEL-1:0] win_s;
    logic [WIDTH_SEL-1:0] idx_s;
    logic                 accept_s;
    logic                 win_last_s;
    int                   idx_i;

    // Winner selection: in LOCK only the owner is eligible.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_i   = 0;
        idx_s   = '0;
        case (fsm_q)
            ST_IDLE: begin
                if (MODE == 1) begin
                    for (int k = 0; k < PORT_NUB; k++) begin
                        idx_i = int'(ptr_q) + k;
                        idx_i = (idx_i >= PORT_NUB) ? (idx_i - PORT_NUB) : idx_i;
                        idx_s = WIDTH_SEL'(idx_i);
                        if (!found_s && req_i[idx_s]) begin
                            found_s = 1'b1;
                            win_s   = idx_s;
                        end else begin
                            found_s = found_s;
                        end
                    end
                end else begin
                    for (int k = 0; k < PORT_NUB; k++) begin
                        idx_s = WIDTH_SEL'(k);
                        if (req_i[idx_s]) begin
                            found_s = 1'b1;
                            win_s   = idx_s;
                        end else begin
                            found_s = found_s;
                        end
                    end
                end
            end
            ST_LOCK: begin
                found_s = req_i[owner_q];
                win_s   = owner_q;
            end
            default: begin
                found_s = 1'b0;
                win_s   = '0;
            end
        endcase
    end

    assign win_last_s = last_i[win_s];
    assign accept_s   = found_s & ~full_i;

    // Next-state: nothing moves unless a beat is accepted, so the lock survives backpressure.
    always_comb begin
        fsm_d      = fsm_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        last_sel_d = last_sel_q;
        if (accept_s) begin
            last_sel_d = win_s;
            if (win_last_s) begin
                fsm_d = ST_IDLE;
                if (MODE == 1) begin
                    ptr_d = (win_s == LAST_IDX) ? '0 : (win_s + WIDTH_SEL'(1));
                end else begin
                    ptr_d = ptr_q;
                end
            end else begin
                fsm_d   = ST_LOCK;
                owner_d = win_s;
            end
        end else begin
            fsm_d = fsm_q;
        end
    end

    // Output decode, forced quiet while reset is held.
    always_comb begin
        grant_o  = '0;
        accept_o = accept_s & ~rst;
        busy_o   = (fsm_q == ST_LOCK) & ~rst;
        if (rst) begin
            sel_o = '0;
        end else if (found_s) begin
            sel_o = win_s;
        end else if (fsm_q == ST_LOCK) begin
            sel_o = owner_q;
        end else begin
            sel_o = last_sel_q;
        end
        if (accept_s && !rst) begin
            grant_o[win_s] = 1'b1;
        end else begin
            grant_o = '0;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            last_sel_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            last_sel_q <= last_sel_d;
        end
    end

endmodule

// File: rtl/mux_ctrl_rr.sv
// Crossbar select controller: transposes input-major request/last vectors into
// per-output vectors and runs one independent arbiter cell per output port.
module mux_ctrl_rr
    import mux_ctrl_rr_pkg::*;
#(
    parameter int  PORT_NUB  = PORT_NUB_TOTAL,
    parameter int  MODE      = 1,
    localparam int WIDTH_SEL = sel_width(PORT_NUB)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORT_NUB*PORT_NUB-1:0]  port_vaild,
    input  logic [PORT_NUB*PORT_NUB-1:0]  port_last,
    input  logic [PORT_NUB-1:0]           full_in,
    output logic [PORT_NUB-1:0]           wr_en_out,
    output logic [WIDTH_SEL*PORT_NUB-1:0] mux_sel,
    output logic [PORT_NUB*PORT_NUB-1:0]  grant_out,
    output logic [PORT_NUB-1:0]           out_busy
);

    for (genvar i = 0; i < PORT_NUB; i++) begin : g_out
        logic [PORT_NUB-1:0]  req_s;
        logic [PORT_NUB-1:0]  last_s;
        logic [PORT_NUB-1:0]  grant_s;
        logic [WIDTH_SEL-1:0] sel_s;
        logic                 acc_s;
        logic                 busy_s;

        for (genvar j = 0; j < PORT_NUB; j++) begin : g_in
            assign req_s[j]                  = port_vaild[j*PORT_NUB+i];
            assign last_s[j]                 = port_last[j*PORT_NUB+i];
            assign grant_out[j*PORT_NUB+i]   = grant_s[j];
        end

        mux_arb_cell #(
            .PORT_NUB (PORT_NUB),
            .MODE     (MODE)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .req_i    (req_s),
            .last_i   (last_s),
            .full_i   (full_in[i]),
            .accept_o (acc_s),
            .sel_o    (sel_s),
            .grant_o  (grant_s),
            .busy_o   (busy_s)
        );

        assign wr_en_out[i]                       = acc_s;
        assign mux_sel[i*WIDTH_SEL +: WIDTH_SEL]  = sel_s;
        assign out_busy[i]                        = busy_s;
    end

endmodule

// File: tb/tb_mux_ctrl_rr.sv
// Directed bench for mux_ctrl_rr: a round-robin instance (a) and a
// fixed-priority instance (b), with hand-computed expectations.
module tb_mux_ctrl_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] va, la, vb, lb;
    logic [3:0]  fa, fb;
    logic [3:0]  wr_a, busy_a, wr_b, busy_b;
    logic [7:0]  sel_a, sel_b;
    logic [15:0] gnt_a, gnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_ctrl_rr #(.PORT_NUB(4), .MODE(1)) u_dut_rr (
        .clk        (clk),
        .rst        (rst),
        .port_vaild (va),
        .port_last  (la),
        .full_in    (fa),
        .wr_en_out  (wr_a),
        .mux_sel    (sel_a),
        .grant_out  (gnt_a),
        .out_busy   (busy_a)
    );

    mux_ctrl_rr #(.PORT_NUB(4), .MODE(0)) u_dut_fp (
        .clk        (clk),
        .rst        (rst),
        .port_vaild (vb),
        .port_last  (lb),
        .full_in    (fb),
        .wr_en_out  (wr_b),
        .mux_sel    (sel_b),
        .grant_out  (gnt_b),
        .out_busy   (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0]  rr_exp [6];
        logic [3:0]  wr_exp4 [6];
        logic [15:0] gnt_exp4 [6];
        logic [7:0]  sel_exp4 [6];
        logic [3:0]  busy_exp4 [6];

        rst = 1'b1;
        va  = 16'hFFFF; la = 16'hFFFF; fa = 4'h0;
        vb  = 16'h0000; lb = 16'h0000; fb = 4'h0;

        // reset holds every output low even with all requests up
        @(negedge clk);
        chk("rst_wr_en",  {28'd0, wr_a},   32'd0);
        chk("rst_grant",  {16'd0, gnt_a},  32'd0);
        chk("rst_sel",    {24'd0, sel_a},  32'd0);
        chk("rst_busy",   {28'd0, busy_a}, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_wr_en",  {28'd0, wr_a},  32'h0000000F);
        chk("rel_grant",  {16'd0, gnt_a}, 32'h0000000F);
        chk("rel_sel",    {24'd0, sel_a}, 32'h00000000);
        next_cycle();
        va = 16'h0000; la = 16'h0000;
        rst_pulse();

        // round robin: inputs 0,1,2 -> output 0, single-beat packets
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        va = 16'h0111; la = 16'h0111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rr_sel_%0d", k), {30'd0, sel_a[1:0]}, {30'd0, rr_exp[k]});
            chk($sformatf("rr_wr_%0d", k),  {31'd0, wr_a[0]},    32'd1);
            next_cycle();
        end
        va = 16'h0000; la = 16'h0000;

        // lock: input 1 sends 3 beats to output 2 while input 3 keeps requesting it
        va = 16'h4040; la = 16'h4000;
        @(negedge clk);
        chk("lock_sel_b1",  {30'd0, sel_a[5:4]}, 32'd1);
        chk("lock_busy_b1", {31'd0, busy_a[2]},  32'd0);
        next_cycle();
        @(negedge clk);
        chk("lock_sel_b2",  {30'd0, sel_a[5:4]}, 32'd1);
        chk("lock_busy_b2", {31'd0, busy_a[2]},  32'd1);
        next_cycle();
        la = 16'h4040;
        @(negedge clk);
        chk("lock_sel_b3",  {30'd0, sel_a[5:4]}, 32'd1);
        chk("lock_busy_b3", {31'd0, busy_a[2]},  32'd1);
        next_cycle();
        va = 16'h4000; la = 16'h4000;
        @(negedge clk);
        chk("lock_sel_in3",  {30'd0, sel_a[5:4]}, 32'd3);
        chk("lock_busy_in3", {31'd0, busy_a[2]},  32'd0);
        chk("lock_gnt_in3",  {16'd0, gnt_a},      32'h00004000);
        next_cycle();
        va = 16'h0000; la = 16'h0000;

        // backpressure on output 2 during beat 2, output 0 streaming alongside
        wr_exp4   = '{4'h5, 4'h1, 4'h1, 4'h5, 4'h5, 4'h5};
        gnt_exp4  = '{16'h0041, 16'h0001, 16'h0001, 16'h0041, 16'h0041, 16'h4001};
        sel_exp4  = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h30};
        busy_exp4 = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
        for (int k = 0; k < 6; k++) begin
            va = (k < 5) ? 16'h4041 : 16'h4001;
            la = (k == 4) ? 16'h4041 : 16'h4001;
            fa = (k == 1 || k == 2) ? 4'h4 : 4'h0;
            @(negedge clk);
            chk($sformatf("bp_wr_%0d", k),   {28'd0, wr_a},   {28'd0, wr_exp4[k]});
            chk($sformatf("bp_gnt_%0d", k),  {16'd0, gnt_a},  {16'd0, gnt_exp4[k]});
            chk($sformatf("bp_sel_%0d", k),  {24'd0, sel_a},  {24'd0, sel_exp4[k]});
            chk($sformatf("bp_busy_%0d", k), {28'd0, busy_a}, {28'd0, busy_exp4[k]});
            next_cycle();
        end
        va = 16'h0000; la = 16'h0000; fa = 4'h0;

        // fixed priority: inputs 0 and 3 -> output 1, input 3 always wins
        vb = 16'h2002; lb = 16'h2002;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("fp_sel_%0d", k), {24'd0, sel_b}, 32'h0000000C);
            chk($sformatf("fp_gnt_%0d", k), {16'd0, gnt_b}, 32'h00002000);
            chk($sformatf("fp_wr_%0d", k),  {28'd0, wr_b},  32'h00000002);
            next_cycle();
        end
        vb = 16'h0000; lb = 16'h0000;

        // reset in the middle of a 3-beat packet from input 2 to output 3
        rst_pulse();
        va = 16'h0800; la = 16'h0000;
        @(negedge clk);
        chk("mid_sel_b1", {30'd0, sel_a[7:6]}, 32'd2);
        next_cycle();
        @(negedge clk);
        chk("mid_busy_b2", {31'd0, busy_a[3]}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {28'd0, busy_a}, 32'd0);
        chk("mid_rst_wr",   {28'd0, wr_a},   32'd0);
        chk("mid_rst_gnt",  {16'd0, gnt_a},  32'd0);
        chk("mid_rst_sel",  {24'd0, sel_a},  32'd0);
        next_cycle();
        rst = 1'b0;
        va = 16'h0808; la = 16'h0808;
        @(negedge clk);
        chk("post_sel",  {30'd0, sel_a[7:6]}, 32'd0);
        chk("post_gnt",  {16'd0, gnt_a},      32'h00000008);
        chk("post_busy", {28'd0, busy_a},     32'd0);
        next_cycle();
        va = 16'h0000; la = 16'h0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
